hazard_ctrl: RTL

- Pipeline control unit that drives the stall, clear and forward inputs of the five-stage RVX10P pipeline registers.
- It consumes the valid bits and register tags those registers propagate.
- It resolves RAW forwarding, load-use stalls and taken-branch flushes, and sequences multi-cycle EX operations through a small FSM.
- It maintains wrap-around performance counters for cycles, retired instructions, stalls and flushes.

---
 rtl/hazard_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// RVX10P pipeline hazard unit: RAW forwarding, load-use stalls, branch flushes,
// multi-cycle EX sequencing and wrap-around performance counters.
module hazard_ctrl #(
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic             valid_E,
    input  logic             LoadE,
    input  logic             PCSrcE,
    input  logic             McStartE,
    input  logic [4:0]       RdM,
    input  logic             RegWriteM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteW,
    input  logic             valid_W,
    input  logic             cnt_clr,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             mc_busy,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic [3:0] MC_LOAD  = 4'(MC_LAT - 1);
    localparam logic       MC_MULTI = (MC_LAT > 1);

    state_e           state_q, state_d;
    logic [3:0]       mc_cnt_q, mc_cnt_d;
    logic [CNT_W-1:0] cycle_q, instret_q, stall_q, flush_q;

    logic [1:0] fwd_a, fwd_b;
    logic       lw_stall;
    logic       stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;

    // Memory-stage result is newer than Writeback, so it wins.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] rd_m, input logic wr_m,
                                           input logic [4:0] rd_w, input logic wr_w);
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
            return 2'b10;
        else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign fwd_a    = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    assign fwd_b    = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    assign lw_stall = valid_E && LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    always_comb begin
        state_d  = state_q;
        mc_cnt_d = mc_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (MC_MULTI && valid_E && McStartE) begin
                    state_d  = BUSY;
                    mc_cnt_d = MC_LOAD;
                end
            end
            BUSY: begin
                if (mc_cnt_q == 4'd1) begin
                    state_d  = IDLE;
                    mc_cnt_d = '0;
                end else begin
                    mc_cnt_d = mc_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                mc_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            mc_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end

    // While busy the whole front end freezes and Memory receives bubbles;
    // branch and load-use requests are held off until the op completes.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        if (state_q == BUSY) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
        end else begin
            stall_f = lw_stall;
            stall_d = lw_stall;
            flush_d = PCSrcE;
            flush_e = lw_stall || PCSrcE;
        end
    end

    // Control outputs are forced low for as long as reset is held.
    assign ForwardAE = reset_n ? fwd_a   : 2'b00;
    assign ForwardBE = reset_n ? fwd_b   : 2'b00;
    assign StallF    = reset_n && stall_f;
    assign StallD    = reset_n && stall_d;
    assign StallE    = reset_n && stall_e;
    assign FlushD    = reset_n && flush_d;
    assign FlushE    = reset_n && flush_e;
    assign FlushM    = reset_n && flush_m;
    assign mc_busy   = reset_n && (state_q == BUSY);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_q   <= '0;
            instret_q <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else if (cnt_clr) begin
            cycle_q   <= '0;
            instret_q <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            cycle_q <= cycle_q + CNT_W'(1);
            if (valid_W)
                instret_q <= instret_q + CNT_W'(1);
            if (stall_d)
                stall_q <= stall_q + CNT_W'(1);
            if (flush_d)
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
    assign stall_cnt   = stall_q;
    assign flush_cnt   = flush_q;

endmodule
